// File: rtl/ecc_result_serializer.sv
// Captures five result bytes on load and streams them over a byte-wide valid/ready link, c0 first.
// Optional build macro ECC_SER_CKSUM_EN appends an XOR checksum byte as the final byte of each frame.
module ecc_result_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] c0,
    input  logic [DATA_W-1:0] c1,
    input  logic [DATA_W-1:0] c2,
    input  logic [DATA_W-1:0] c3,
    input  logic [DATA_W-1:0] c4,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

`ifdef ECC_SER_CKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_CKSUM} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SEND} state_t;
`endif

    state_t            r_state;
    logic [2:0]        r_idx;
    logic [DATA_W-1:0] r_hold [5];
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_busy;
    logic              r_done;

    state_t            w_state_nxt;
    logic [2:0]        w_idx_nxt;
    logic              w_capture;
    logic              w_done_nxt;
    logic              w_xfer;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_valid_nxt;
    logic              w_last_nxt;
`ifdef ECC_SER_CKSUM_EN
    logic [DATA_W-1:0] w_cksum;

    assign w_cksum = r_hold[0] ^ r_hold[1] ^ r_hold[2] ^ r_hold[3] ^ r_hold[4];
`endif

    assign w_xfer = r_out_valid & out_ready;

    // Next-state logic plus the values the output registers take on the coming edge.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_capture   = 1'b0;
        w_done_nxt  = 1'b0;
        w_data_nxt  = '0;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_capture   = 1'b1;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (w_xfer) begin
                    if (r_idx == 3'd4) begin
`ifdef ECC_SER_CKSUM_EN
                        w_state_nxt = S_CKSUM;
`else
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
`endif
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
`ifdef ECC_SER_CKSUM_EN
            S_CKSUM: begin
                if (w_xfer) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase

        // The holding register is not yet written on the capture edge, so c0 is taken directly.
        case (w_state_nxt)
            S_SEND: begin
                w_valid_nxt = 1'b1;
                w_data_nxt  = w_capture ? c0 : r_hold[w_idx_nxt];
`ifndef ECC_SER_CKSUM_EN
                w_last_nxt  = (w_idx_nxt == 3'd4);
`endif
            end
`ifdef ECC_SER_CKSUM_EN
            S_CKSUM: begin
                w_valid_nxt = 1'b1;
                w_data_nxt  = w_cksum;
                w_last_nxt  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_idx       <= 3'd0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            for (int i = 0; i < 5; i++) r_hold[i] <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_out_data  <= w_data_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_last  <= w_last_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= w_done_nxt;
            if (w_capture) begin
                r_hold[0] <= c0;
                r_hold[1] <= c1;
                r_hold[2] <= c2;
                r_hold[3] <= c3;
                r_hold[4] <= c4;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_ecc_result_serializer.sv
// Scoreboard bench for ecc_result_serializer: stimulus pushes expected bytes, a negedge monitor pops on each transfer.
module tb_ecc_result_serializer;

`ifdef ECC_SER_CKSUM_EN
    localparam int LEN = 6;
`else
    localparam int LEN = 5;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] c0, c1, c2, c3, c4;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    logic mon_en = 1'b0;
    logic exp_done = 1'b0;

    always #5 clk = ~clk;

    ecc_result_serializer #(.DATA_W(8)) dut (
        .clk(clk), .reset(reset), .load(load),
        .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // Monitor: every transfer must match the head of the queue; done must follow the last byte by one cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("done_pulse", 32'(done), 32'(exp_done));
            if (done) chk("busy_at_done", 32'(busy), 32'd0);
            if (out_valid && out_ready && reset) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte: got %0h want none", out_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("data", 32'(out_data), 32'(e.d));
                    chk("last", 32'(out_last), 32'(e.l));
                end
                exp_done = out_last;
            end else begin
                exp_done = 1'b0;
            end
        end
    end

    task automatic push_frame(input logic [7:0] b0, b1, b2, b3, b4);
        q.push_back('{d: b0, l: 1'b0});
        q.push_back('{d: b1, l: 1'b0});
        q.push_back('{d: b2, l: 1'b0});
        q.push_back('{d: b3, l: 1'b0});
`ifdef ECC_SER_CKSUM_EN
        q.push_back('{d: b4, l: 1'b0});
        q.push_back('{d: b0 ^ b1 ^ b2 ^ b3 ^ b4, l: 1'b1});
`else
        q.push_back('{d: b4, l: 1'b1});
`endif
    endtask

    // Presents a load for one edge; caller ensures the DUT is idle at that edge.
    task automatic do_load(input logic [7:0] b0, b1, b2, b3, b4);
        load = 1'b1;
        c0 = b0; c1 = b1; c2 = b2; c3 = b3; c4 = b4;
        push_frame(b0, b1, b2, b3, b4);
        @(posedge clk);
        #1;
        load = 1'b0;
        c0 = 8'hEE; c1 = 8'hEE; c2 = 8'hEE; c3 = 8'hEE; c4 = 8'hEE;
    endtask

    task automatic wait_done(input int exp_n);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                n = i;
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        else if (exp_n > 0) chk("done_latency", 32'(n), 32'(exp_n));
        chk("queue_drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        load = 1'b1;
        out_ready = 1'b1;
        c0 = 8'hC0; c1 = 8'hC1; c2 = 8'hC2; c3 = 8'hC3; c4 = 8'hC4;

        // Reset held three cycles with load high: nothing captured, all outputs zero.
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_data", 32'(out_data), 32'd0);
            chk("rst_last", 32'(out_last), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
        end
        reset = 1'b1;
        load = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        // Basic frame with out_ready held high.
        @(posedge clk);
        #1;
        do_load(8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
        wait_done(LEN + 1);

        // Back-to-back: load in the done cycle.
        do_load(8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
        @(negedge clk);
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_first", 32'(out_data), 32'h01);
        wait_done(LEN);

        // Backpressure for three cycles while presenting 33.
        @(posedge clk);
        #1;
        do_load(8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'h33);
            chk("stall_last", 32'(out_last), 32'd0);
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        wait_done(-1);

        // Load while busy must be ignored.
        @(posedge clk);
        #1;
        do_load(8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
        repeat (2) @(posedge clk);
        #1;
        load = 1'b1;
        c0 = 8'hAA; c1 = 8'hAB; c2 = 8'hAC; c3 = 8'hAD; c4 = 8'hAE;
        @(posedge clk);
        #1;
        load = 1'b0;
        wait_done(-1);

        // Reset after two transfers: frame dropped, no done, next load restarts at c0.
        @(posedge clk);
        #1;
        do_load(8'h66, 8'h77, 8'h88, 8'h99, 8'hA5);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        q.delete();
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_last", 32'(out_last), 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        do_load(8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E);
        wait_done(LEN + 1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
